regfile_bypass_mp: RTL

REGFILE_BYPASS_MP -- requirements
Module: regfile_bypass_mp

---
 rtl/regfile_bypass_mp.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/regfile_bypass_mp.sv
// -----------------------------------------------------------------------------
// regfile_bypass_mp
// Multi-read-port register file with two write ports, same-cycle
// write-to-read forwarding, an optional hardwired-zero register 0 and sticky
// error status.
//
// Ports
//   clk            single clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   rd_en[NRD]     per-port read-valid qualifier (only affects uninit_rd)
//   rd_sel         read selects, port i at [i*ADDR_W +: ADDR_W]
//   rd_data        combinational read data, port i at [i*WIDTH +: WIDTH]
//   wr0_*/wr1_*    write ports; port 1 wins on a same-register dual write
//   bypass_dis     1 = reads return stored content, ignoring pending writes
//   err_clr        synchronous clear of the sticky flags
//   wr_conflict    sticky: same-register dual write seen
//   uninit_rd      sticky: enabled read of a never-written register
//   err            wr_conflict OR uninit_rd
// -----------------------------------------------------------------------------
module regfile_bypass_mp #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD-1:0]          rd_en,
  input  logic [NRD*ADDR_W-1:0]   rd_sel,
  output logic [NRD*WIDTH-1:0]    rd_data,
  input  logic                    wr0_en,
  input  logic [ADDR_W-1:0]       wr0_sel,
  input  logic [WIDTH-1:0]        wr0_data,
  input  logic                    wr1_en,
  input  logic [ADDR_W-1:0]       wr1_sel,
  input  logic [WIDTH-1:0]        wr1_data,
  input  logic                    bypass_dis,
  input  logic                    err_clr,
  output logic                    wr_conflict,
  output logic                    uninit_rd,
  output logic                    err
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam bit                ZR       = (ZERO_REG != 32'sd0);
  localparam logic [ADDR_W-1:0] ZERO_SEL = {ADDR_W{1'b0}};

  logic [WIDTH-1:0]             r_regs [DEPTH];
  logic [DEPTH-1:0]             r_mask;
  logic                         r_wr_conflict;
  logic                         r_uninit_rd;
  logic                         r_err;

  logic                         w_wr0_act;
  logic                         w_wr1_act;
  logic                         w_conflict_evt;
  logic                         w_wr0_store;
  logic                         w_uninit_evt;
  logic                         w_conflict_nxt;
  logic                         w_uninit_nxt;
  logic [NRD-1:0][ADDR_W-1:0]   w_sel;
  logic [NRD-1:0]               w_is_zero;
  logic [NRD-1:0]               w_hit0;
  logic [NRD-1:0]               w_hit1;
  logic [NRD*WIDTH-1:0]         w_rd_data;

  // A write is live only out of reset and never to a hardwired-zero register,
  // so it neither stores, forwards nor raises a conflict in those cases.
  assign w_wr0_act      = wr0_en & rst & ~(ZR & (wr0_sel == ZERO_SEL));
  assign w_wr1_act      = wr1_en & rst & ~(ZR & (wr1_sel == ZERO_SEL));
  assign w_conflict_evt = w_wr0_act & w_wr1_act & (wr0_sel == wr1_sel);
  assign w_wr0_store    = w_wr0_act & ~w_conflict_evt;

  // Read muxes with forwarding (port 1 data wins) and uninitialised-read detection.
  always_comb begin
    w_sel        = '0;
    w_is_zero    = '0;
    w_hit0       = '0;
    w_hit1       = '0;
    w_rd_data    = '0;
    w_uninit_evt = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      w_sel[i]     = rd_sel[i*ADDR_W +: ADDR_W];
      w_is_zero[i] = ZR & (w_sel[i] == ZERO_SEL);
      w_hit0[i]    = ~bypass_dis & w_wr0_act & (wr0_sel == w_sel[i]);
      w_hit1[i]    = ~bypass_dis & w_wr1_act & (wr1_sel == w_sel[i]);
      if (!rst) begin
        w_rd_data[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end else if (w_is_zero[i]) begin
        w_rd_data[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end else if (w_hit1[i]) begin
        w_rd_data[i*WIDTH +: WIDTH] = wr1_data;
      end else if (w_hit0[i]) begin
        w_rd_data[i*WIDTH +: WIDTH] = wr0_data;
      end else begin
        w_rd_data[i*WIDTH +: WIDTH] = r_regs[w_sel[i]];
      end
      // A forwarded value counts as initialised data for this read.
      if (rst && rd_en[i] && !w_is_zero[i] && !r_mask[w_sel[i]] &&
          !(w_hit0[i] | w_hit1[i])) begin
        w_uninit_evt = 1'b1;
      end else begin
        w_uninit_evt = w_uninit_evt;
      end
    end
  end

  assign rd_data = w_rd_data;

  // Next-state of the sticky flags: a new event beats a same-edge clear.
  always_comb begin
    w_conflict_nxt = r_wr_conflict;
    w_uninit_nxt   = r_uninit_rd;
    if (w_conflict_evt) begin
      w_conflict_nxt = 1'b1;
    end else if (err_clr) begin
      w_conflict_nxt = 1'b0;
    end else begin
      w_conflict_nxt = r_wr_conflict;
    end
    if (w_uninit_evt) begin
      w_uninit_nxt = 1'b1;
    end else if (err_clr) begin
      w_uninit_nxt = 1'b0;
    end else begin
      w_uninit_nxt = r_uninit_rd;
    end
  end

  // Register array and written mask; port 1 is applied last so it wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= {WIDTH{1'b0}};
      end
      r_mask <= {DEPTH{1'b0}};
    end else begin
      if (w_wr0_store) begin
        r_regs[wr0_sel] <= wr0_data;
        r_mask[wr0_sel] <= 1'b1;
      end
      if (w_wr1_act) begin
        r_regs[wr1_sel] <= wr1_data;
        r_mask[wr1_sel] <= 1'b1;
      end
    end
  end

  // Sticky status flags; err is registered alongside so it is glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_conflict <= 1'b0;
      r_uninit_rd   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_wr_conflict <= w_conflict_nxt;
      r_uninit_rd   <= w_uninit_nxt;
      r_err         <= w_conflict_nxt | w_uninit_nxt;
    end
  end

  assign wr_conflict = r_wr_conflict;
  assign uninit_rd   = r_uninit_rd;
  assign err         = r_err;

endmodule
